// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Signal bundle between the instruction-fetch stage and its surroundings:
//   decode-side control (stall/flush/redirect), the combinational instruction
//   ROM port, the IF/ID pipeline register outputs and status.
//
//   Flow control: there is no valid/ready pair here. stall_i is the only
//   back-pressure. While it is high and no redirect/flush is present, IF/ID
//   and the PC hold, so decode sees the same word until stall_i drops.
//   if_id_valid_o qualifies the IF/ID contents (0 = bubble).
//
//   modport master : the fetch stage (drives ROM address and IF/ID outputs)
//   modport slave  : decode/ROM/environment side
// -----------------------------------------------------------------------------
interface fetch_stage_if;
   logic        stall_i;
   logic        flush_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_instr_i;
   logic [31:0] if_id_pc_o;
   logic [31:0] if_id_pc4_o;
   logic [31:0] if_id_instr_o;
   logic        if_id_valid_o;
   logic        fetch_fault_o;
   logic [31:0] fetch_count_o;
   logic        fetch_state_o;   // debug: 0 = RUN, 1 = HALT

   modport master (
      input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_instr_i,
      output imem_addr_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o,
             if_id_valid_o, fetch_fault_o, fetch_count_o, fetch_state_o
   );

   modport slave (
      output stall_i, flush_i, redirect_i, redirect_pc_i, imem_instr_i,
      input  imem_addr_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o,
             if_id_valid_o, fetch_fault_o, fetch_count_o, fetch_state_o
   );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. Owns the PC, addresses a combinational
//   instruction ROM and captures {pc, pc+4, word, valid} into IF/ID.
//   Handles decode stalls, flushes, branch/jump redirects, and halts on an
//   illegal (misaligned or out-of-range) fetch address until redirected.
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - fetch_stage_if.master (control in, ROM port, IF/ID out,
//              fault/count status, debug FSM state)
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_BYTES = 1024,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_stage_if.master bus
);

   localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic        fault_q, fault_d;
   logic [31:0] count_q, count_d;

   logic        legal;
   logic [31:0] pc_plus4;

   assign legal    = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_ADDR);
   assign pc_plus4 = pc_q + 32'd4;

   // ROM is only ever presented an in-range address.
   assign bus.imem_addr_o = legal ? pc_q : 32'h0;

   // Next-state and next-register values. Bubble loads are written out
   // inline so each branch reads as one complete IF/ID update.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      fault_d      = fault_q;
      count_d      = count_q;

      case (state_q)
         RUN: begin
            if (bus.redirect_i) begin
               // Wrong-path word is dropped even if decode is stalling.
               pc_d         = bus.redirect_pc_i;
               ifid_pc_d    = 32'h0;
               ifid_pc4_d   = 32'h0;
               ifid_instr_d = NOP_INSTR;
               ifid_valid_d = 1'b0;
            end else if (bus.flush_i) begin
               ifid_pc_d    = 32'h0;
               ifid_pc4_d   = 32'h0;
               ifid_instr_d = NOP_INSTR;
               ifid_valid_d = 1'b0;
               if (!bus.stall_i) pc_d = pc_plus4;
            end else if (bus.stall_i) begin
               // hold everything
            end else if (legal) begin
               pc_d         = pc_plus4;
               ifid_pc_d    = pc_q;
               ifid_pc4_d   = pc_plus4;
               ifid_instr_d = bus.imem_instr_i;
               ifid_valid_d = 1'b1;
               count_d      = count_q + 32'd1;
            end else begin
               // Illegal fetch: park here with the PC frozen for debug.
               ifid_pc_d    = 32'h0;
               ifid_pc4_d   = 32'h0;
               ifid_instr_d = NOP_INSTR;
               ifid_valid_d = 1'b0;
               fault_d      = 1'b1;
               state_d      = HALT;
            end
         end

         HALT: begin
            ifid_pc_d    = 32'h0;
            ifid_pc4_d   = 32'h0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            if (bus.redirect_i) begin
               pc_d    = bus.redirect_pc_i;
               fault_d = 1'b0;
               state_d = RUN;
            end
         end

         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         pc_q         <= RESET_PC;
         ifid_pc_q    <= 32'h0;
         ifid_pc4_q   <= 32'h0;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
         fault_q      <= 1'b0;
         count_q      <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
         fault_q      <= fault_d;
         count_q      <= count_d;
      end
   end

   assign bus.if_id_pc_o    = ifid_pc_q;
   assign bus.if_id_pc4_o   = ifid_pc4_q;
   assign bus.if_id_instr_o = ifid_instr_q;
   assign bus.if_id_valid_o = ifid_valid_q;
   assign bus.fetch_fault_o = fault_q;
   assign bus.fetch_count_o = count_q;
   assign bus.fetch_state_o = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. ROM word k = 32'h1000_0000 + k.
//   Each scenario task drives stimulus and compares inline.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   fetch_stage_if fif ();

   fetch_stage #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_BYTES (1024),
      .NOP_INSTR  (NOP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (fif)
   );

   // Combinational ROM model, word index from byte address.
   assign fif.imem_instr_i = 32'h1000_0000 + {22'h0, fif.imem_addr_o[9:2]};

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fif.stall_i       = 1'b0;
      fif.flush_i       = 1'b0;
      fif.redirect_i    = 1'b0;
      fif.redirect_pc_i = 32'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #12;
      n_checks++; if (fif.if_id_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", fif.if_id_pc_o, 32'h0); end
      n_checks++; if (fif.if_id_pc4_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h want %h", fif.if_id_pc4_o, 32'h0); end
      n_checks++; if (fif.if_id_instr_o !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", fif.if_id_instr_o, NOP); end
      n_checks++; if (fif.if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", fif.if_id_valid_o); end
      n_checks++; if (fif.fetch_fault_o !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fif.fetch_fault_o); end
      n_checks++; if (fif.fetch_count_o !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %h want 0", fif.fetch_count_o); end
      n_checks++; if (fif.imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", fif.imem_addr_o); end
      n_checks++; if (fif.fetch_state_o !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0", fif.fetch_state_o); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         exp_pc = 32'(k * 4);
         step();
         n_checks++; if (fif.if_id_pc_o !== exp_pc) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", k, fif.if_id_pc_o, exp_pc); end
         n_checks++; if (fif.if_id_pc4_o !== exp_pc + 32'd4) begin n_fail++; $display("FAIL seq_pc4[%0d]: got %h want %h", k, fif.if_id_pc4_o, exp_pc + 32'd4); end
         n_checks++; if (fif.if_id_instr_o !== 32'h1000_0000 + 32'(k)) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h want %h", k, fif.if_id_instr_o, 32'h1000_0000 + 32'(k)); end
         n_checks++; if (fif.if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", k, fif.if_id_valid_o); end
      end
      n_checks++; if (fif.fetch_count_o !== 32'd3) begin n_fail++; $display("FAIL seq_count: got %0d want 3", fif.fetch_count_o); end
      n_checks++; if (fif.imem_addr_o !== 32'hC) begin n_fail++; $display("FAIL seq_addr: got %h want c", fif.imem_addr_o); end
   endtask

   task automatic test_stall();
      do_reset();
      step();
      step();   // IF/ID holds pc 4, PC = 8
      fif.stall_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         n_checks++; if (fif.if_id_pc_o !== 32'h4) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 4", k, fif.if_id_pc_o); end
         n_checks++; if (fif.if_id_instr_o !== 32'h1000_0001) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want 10000001", k, fif.if_id_instr_o); end
         n_checks++; if (fif.fetch_count_o !== 32'd2) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d want 2", k, fif.fetch_count_o); end
         n_checks++; if (fif.imem_addr_o !== 32'h8) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h want 8", k, fif.imem_addr_o); end
      end
      fif.stall_i = 1'b0;
      step();
      n_checks++; if (fif.if_id_pc_o !== 32'h8) begin n_fail++; $display("FAIL stall_resume_pc: got %h want 8", fif.if_id_pc_o); end
      n_checks++; if (fif.if_id_instr_o !== 32'h1000_0002) begin n_fail++; $display("FAIL stall_resume_instr: got %h want 10000002", fif.if_id_instr_o); end
      n_checks++; if (fif.fetch_count_o !== 32'd3) begin n_fail++; $display("FAIL stall_resume_count: got %0d want 3", fif.fetch_count_o); end
      step();
      n_checks++; if (fif.if_id_pc_o !== 32'hC) begin n_fail++; $display("FAIL stall_next_pc: got %h want c", fif.if_id_pc_o); end
   endtask

   task automatic test_flush();
      do_reset();
      step();   // IF/ID pc 0, PC = 4
      fif.flush_i = 1'b1;
      fif.stall_i = 1'b1;
      step();   // bubble, PC holds at 4
      n_checks++; if (fif.if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall_valid: got %b want 0", fif.if_id_valid_o); end
      n_checks++; if (fif.if_id_instr_o !== NOP) begin n_fail++; $display("FAIL flush_stall_instr: got %h want %h", fif.if_id_instr_o, NOP); end
      n_checks++; if (fif.imem_addr_o !== 32'h4) begin n_fail++; $display("FAIL flush_stall_addr: got %h want 4", fif.imem_addr_o); end
      fif.stall_i = 1'b0;
      step();   // bubble, PC advances to 8
      n_checks++; if (fif.if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", fif.if_id_valid_o); end
      n_checks++; if (fif.imem_addr_o !== 32'h8) begin n_fail++; $display("FAIL flush_addr: got %h want 8", fif.imem_addr_o); end
      n_checks++; if (fif.fetch_count_o !== 32'd1) begin n_fail++; $display("FAIL flush_count: got %0d want 1", fif.fetch_count_o); end
      fif.flush_i = 1'b0;
      step();
      n_checks++; if (fif.if_id_pc_o !== 32'h8) begin n_fail++; $display("FAIL flush_resume_pc: got %h want 8", fif.if_id_pc_o); end
   endtask

   task automatic test_redirect_stall();
      do_reset();
      step();
      step();
      fif.redirect_i    = 1'b1;
      fif.redirect_pc_i = 32'h40;
      fif.stall_i       = 1'b1;
      step();
      n_checks++; if (fif.if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b want 0", fif.if_id_valid_o); end
      n_checks++; if (fif.if_id_pc_o !== 32'h0) begin n_fail++; $display("FAIL redir_bubble_pc: got %h want 0", fif.if_id_pc_o); end
      n_checks++; if (fif.imem_addr_o !== 32'h40) begin n_fail++; $display("FAIL redir_addr: got %h want 40", fif.imem_addr_o); end
      idle_inputs();
      step();
      n_checks++; if (fif.if_id_pc_o !== 32'h40) begin n_fail++; $display("FAIL redir_tgt_pc: got %h want 40", fif.if_id_pc_o); end
      n_checks++; if (fif.if_id_pc4_o !== 32'h44) begin n_fail++; $display("FAIL redir_tgt_pc4: got %h want 44", fif.if_id_pc4_o); end
      n_checks++; if (fif.if_id_instr_o !== 32'h1000_0010) begin n_fail++; $display("FAIL redir_tgt_instr: got %h want 10000010", fif.if_id_instr_o); end
      n_checks++; if (fif.if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL redir_tgt_valid: got %b want 1", fif.if_id_valid_o); end
      n_checks++; if (fif.fetch_count_o !== 32'd3) begin n_fail++; $display("FAIL redir_count: got %0d want 3", fif.fetch_count_o); end
   endtask

   task automatic test_overrun();
      do_reset();
      fif.redirect_i    = 1'b1;
      fif.redirect_pc_i = 32'h3F8;
      step();
      idle_inputs();
      step();   // IF/ID 0x3F8
      step();   // IF/ID 0x3FC, PC = 0x400
      n_checks++; if (fif.if_id_pc_o !== 32'h3FC) begin n_fail++; $display("FAIL ovr_last_pc: got %h want 3fc", fif.if_id_pc_o); end
      n_checks++; if (fif.if_id_instr_o !== 32'h1000_00FF) begin n_fail++; $display("FAIL ovr_last_instr: got %h want 100000ff", fif.if_id_instr_o); end
      n_checks++; if (fif.if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL ovr_last_valid: got %b want 1", fif.if_id_valid_o); end
      n_checks++; if (fif.imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL ovr_addr: got %h want 0", fif.imem_addr_o); end
      step();
      n_checks++; if (fif.fetch_fault_o !== 1'b1) begin n_fail++; $display("FAIL ovr_fault: got %b want 1", fif.fetch_fault_o); end
      n_checks++; if (fif.fetch_state_o !== 1'b1) begin n_fail++; $display("FAIL ovr_halt: got %b want 1", fif.fetch_state_o); end
      n_checks++; if (fif.if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL ovr_bubble: got %b want 0", fif.if_id_valid_o); end
      n_checks++; if (fif.fetch_count_o !== 32'd2) begin n_fail++; $display("FAIL ovr_count: got %0d want 2", fif.fetch_count_o); end
      // stall/flush are ignored while halted
      fif.stall_i = 1'b1;
      fif.flush_i = 1'b1;
      step();
      n_checks++; if (fif.fetch_state_o !== 1'b1) begin n_fail++; $display("FAIL ovr_halt_hold: got %b want 1", fif.fetch_state_o); end
      n_checks++; if (fif.fetch_fault_o !== 1'b1) begin n_fail++; $display("FAIL ovr_fault_hold: got %b want 1", fif.fetch_fault_o); end
      idle_inputs();
      fif.redirect_i    = 1'b1;
      fif.redirect_pc_i = 32'h0;
      step();
      n_checks++; if (fif.fetch_fault_o !== 1'b0) begin n_fail++; $display("FAIL ovr_clear_fault: got %b want 0", fif.fetch_fault_o); end
      n_checks++; if (fif.fetch_state_o !== 1'b0) begin n_fail++; $display("FAIL ovr_run: got %b want 0", fif.fetch_state_o); end
      n_checks++; if (fif.if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL ovr_redir_bubble: got %b want 0", fif.if_id_valid_o); end
      idle_inputs();
      step();
      n_checks++; if (fif.if_id_pc_o !== 32'h0 || fif.if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL ovr_resume: got pc %h valid %b want pc 0 valid 1", fif.if_id_pc_o, fif.if_id_valid_o); end
      n_checks++; if (fif.if_id_instr_o !== 32'h1000_0000) begin n_fail++; $display("FAIL ovr_resume_instr: got %h want 10000000", fif.if_id_instr_o); end
   endtask

   task automatic test_misaligned();
      do_reset();
      fif.redirect_i    = 1'b1;
      fif.redirect_pc_i = 32'h42;
      step();
      idle_inputs();
      n_checks++; if (fif.fetch_fault_o !== 1'b0) begin n_fail++; $display("FAIL mis_no_fault_yet: got %b want 0", fif.fetch_fault_o); end
      n_checks++; if (fif.imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL mis_addr: got %h want 0", fif.imem_addr_o); end
      step();
      n_checks++; if (fif.fetch_fault_o !== 1'b1) begin n_fail++; $display("FAIL mis_fault: got %b want 1", fif.fetch_fault_o); end
      n_checks++; if (fif.fetch_state_o !== 1'b1) begin n_fail++; $display("FAIL mis_halt: got %b want 1", fif.fetch_state_o); end
      for (int k = 0; k < 2; k++) begin
         step();
         n_checks++; if (fif.if_id_valid_o !== 1'b0 || fif.if_id_instr_o !== NOP) begin n_fail++; $display("FAIL mis_bubble[%0d]: got valid %b instr %h want 0 %h", k, fif.if_id_valid_o, fif.if_id_instr_o, NOP); end
      end
      fif.redirect_i    = 1'b1;
      fif.redirect_pc_i = 32'h44;
      step();
      idle_inputs();
      n_checks++; if (fif.fetch_fault_o !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", fif.fetch_fault_o); end
      step();
      n_checks++; if (fif.if_id_pc_o !== 32'h44) begin n_fail++; $display("FAIL mis_tgt_pc: got %h want 44", fif.if_id_pc_o); end
      n_checks++; if (fif.if_id_instr_o !== 32'h1000_0011) begin n_fail++; $display("FAIL mis_tgt_instr: got %h want 10000011", fif.if_id_instr_o); end
   endtask

   task automatic test_async_reset();
      do_reset();
      step();
      step();
      step();
      #3;   // between edges
      rst_n = 1'b0;
      #1;
      n_checks++; if (fif.if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", fif.if_id_valid_o); end
      n_checks++; if (fif.if_id_pc_o !== 32'h0) begin n_fail++; $display("FAIL arst_pc: got %h want 0", fif.if_id_pc_o); end
      n_checks++; if (fif.if_id_instr_o !== NOP) begin n_fail++; $display("FAIL arst_instr: got %h want %h", fif.if_id_instr_o, NOP); end
      n_checks++; if (fif.fetch_count_o !== 32'h0) begin n_fail++; $display("FAIL arst_count: got %0d want 0", fif.fetch_count_o); end
      n_checks++; if (fif.imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL arst_addr: got %h want 0", fif.imem_addr_o); end
      #2;
      rst_n = 1'b1;
      step();
      n_checks++; if (fif.if_id_pc_o !== 32'h0 || fif.if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL arst_restart: got pc %h valid %b want pc 0 valid 1", fif.if_id_pc_o, fif.if_id_valid_o); end
      n_checks++; if (fif.fetch_count_o !== 32'd1) begin n_fail++; $display("FAIL arst_restart_count: got %0d want 1", fif.fetch_count_o); end
   endtask

   // ---------------- main ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      idle_inputs();
      test_reset();
      test_sequential();
      test_stall();
      test_flush();
      test_redirect_stall();
      test_overrun();
      test_misaligned();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
